rect_cyl: RTL and testbench

//  Rectangular-to-cylindrical (polar) converter for the first quadrant. Top-level user tile:

---
 rtl/rect_cyl_pkg.sv | 137 +++++++++++++
 rtl/rect_cyl_isqrt.sv | 43 ++++
 rtl/rect_cyl.sv | 107 ++++++++++
 tb/tb_rect_cyl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rect_cyl_pkg.sv
// Shared constants, stage records and per-iteration helper functions for the
// rectangular-to-cylindrical converter (radius via integer sqrt, angle via CORDIC).
package rect_cyl_pkg;

  localparam int LATENCY   = 4;   // edges from input sample to matching output
  localparam int CORDIC_IT = 8;   // CORDIC vectoring iterations

  localparam int IN_W   = 8;      // x / y input width
  localparam int SQ_W   = 17;     // x*x + y*y
  localparam int RAD_W  = 18;     // radicand padded to an even bit count
  localparam int ROOT_W = 9;      // sqrt result bits
  localparam int REM_W  = 10;     // restoring remainder, always <= 2*root
  localparam int CW     = 10;     // CORDIC x/y datapath width
  localparam int ZW     = 16;     // CORDIC angle accumulator, degrees Q8.8

  // atan(2^-i) in degrees, Q8.8
  localparam logic [ZW-1:0] ATAN_DEG_Q8_8 [CORDIC_IT] = '{
    16'd11520, 16'd6801, 16'd3593, 16'd1824, 16'd916, 16'd458, 16'd229, 16'd115
  };

  // How the final angle is chosen; exact cases bypass the CORDIC result.
  typedef enum logic [1:0] {
    SEL_CORDIC = 2'd0,
    SEL_0      = 2'd1,
    SEL_45     = 2'd2,
    SEL_90     = 2'd3
  } theta_sel_e;

  // CORDIC stage record. x is a magnitude that only grows during vectoring
  // from the first quadrant, so it is kept unsigned (peaks near 594); y is
  // two's complement and stays within +/-256.
  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [ZW-1:0] z;
    theta_sel_e    sel;
  } cordic_t;

  // Restoring square-root stage record; rad holds the radicand pairs not yet
  // consumed, left-aligned.
  typedef struct packed {
    logic [REM_W-1:0]  rem;
    logic [ROOT_W-1:0] root;
    logic [RAD_W-1:0]  rad;
  } sqrt_t;

  // Left shift that brings max(x,y) into 128..255; the ratio, and hence the
  // angle, is unchanged while small inputs gain CORDIC precision.
  function automatic logic [2:0] norm_shift(input logic [IN_W-1:0] m);
    logic [2:0] sh;
    casez (m)
      8'b1???????: sh = 3'd0;
      8'b01??????: sh = 3'd1;
      8'b001?????: sh = 3'd2;
      8'b0001????: sh = 3'd3;
      8'b00001???: sh = 3'd4;
      8'b000001??: sh = 3'd5;
      8'b0000001?: sh = 3'd6;
      default:     sh = 3'd7;
    endcase
    return sh;
  endfunction

  // One CORDIC vectoring micro-rotation, driving y toward zero.
  function automatic cordic_t cordic_step(input cordic_t c, input logic [2:0] i);
    cordic_t                r;
    logic signed [11:0]     xs, ys, xsh, ysh;
    logic [CW-1:0]          xn, yn;
    logic signed [ZW-1:0]   zn;
    xs  = {2'b00, c.x};
    ys  = {{2{c.y[CW-1]}}, c.y};
    xsh = xs >>> i;
    ysh = ys >>> i;
    if (c.y[CW-1]) begin
      xn = CW'(xs - ysh);
      yn = CW'(ys + xsh);
      zn = $signed(c.z) - $signed(ATAN_DEG_Q8_8[i]);
    end else begin
      xn = CW'(xs + ysh);
      yn = CW'(ys - xsh);
      zn = $signed(c.z) + $signed(ATAN_DEG_Q8_8[i]);
    end
    r     = c;
    r.x   = xn;
    r.y   = yn;
    r.z   = zn;
    return r;
  endfunction

  // Final two iterations; only the accumulated angle is needed afterwards.
  function automatic logic [ZW-1:0] cordic_last2(input cordic_t c);
    cordic_t c6;
    logic [ZW-1:0] z;
    c6 = cordic_step(c, 3'd6);
    if (c6.y[CW-1]) z = c6.z - ATAN_DEG_Q8_8[7];
    else            z = c6.z + ATAN_DEG_Q8_8[7];
    return z;
  endfunction

  // Round Q8.8 degrees to nearest integer and clamp to 0..90.
  function automatic logic [7:0] theta_round(input logic [ZW-1:0] z);
    logic signed [ZW-1:0] t;
    logic [7:0]           deg;
    t = $signed(z) + 16'sd128;
    t = t >>> 8;
    if (t < 16'sd0)       deg = 8'd0;
    else if (t > 16'sd90) deg = 8'd90;
    else                  deg = t[7:0];
    return deg;
  endfunction

  // One restoring square-root step: bring down the next radicand pair and
  // try to set the next root bit.
  function automatic sqrt_t isqrt_step(input sqrt_t s);
    sqrt_t       r;
    logic [11:0] rem_sh, trial;
    rem_sh = {s.rem, s.rad[RAD_W-1 -: 2]};
    trial  = {1'b0, s.root, 2'b01};
    r.rad  = {s.rad[RAD_W-3:0], 2'b00};
    if (rem_sh >= trial) begin
      r.rem  = REM_W'(rem_sh - trial);
      r.root = {s.root[ROOT_W-2:0], 1'b1};
    end else begin
      r.rem  = REM_W'(rem_sh);
      r.root = {s.root[ROOT_W-2:0], 1'b0};
    end
    return r;
  endfunction

  // Last three steps; only the root survives.
  function automatic logic [ROOT_W-1:0] isqrt_last3(input sqrt_t s);
    sqrt_t t;
    t = isqrt_step(isqrt_step(isqrt_step(s)));
    return t.root;
  endfunction

endpackage

// File: rtl/rect_cyl_isqrt.sv
// Pipelined restoring integer square root of a 17-bit value: three result
// bits per stage over three registered stages, all stages gated by ena_i.
module rect_cyl_isqrt
  import rect_cyl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ena_i,
  input  logic [SQ_W-1:0]   sq_i,
  output logic [ROOT_W-1:0] root_o
);

  sqrt_t             st0;
  sqrt_t             st1_d, st1_q;
  sqrt_t             st2_d, st2_q;
  logic [ROOT_W-1:0] root_d, root_q;

  // Stage steps: bits 8..6, 5..3, 2..0 of the root.
  always_comb begin
    st0.rem  = '0;
    st0.root = '0;
    st0.rad  = {1'b0, sq_i};
    st1_d    = isqrt_step(isqrt_step(isqrt_step(st0)));
    st2_d    = isqrt_step(isqrt_step(isqrt_step(st1_q)));
    root_d   = isqrt_last3(st2_q);
  end

  // Stage registers; synchronous active-high clear, hold when not enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st1_q  <= '0;
      st2_q  <= '0;
      root_q <= '0;
    end else if (ena_i) begin
      st1_q  <= st1_d;
      st2_q  <= st2_d;
      root_q <= root_d;
    end
  end

  assign root_o = root_q;

endmodule

// File: rtl/rect_cyl.sv
// First-quadrant rectangular-to-polar converter. Streaming, no handshake:
// a pair sampled on an enabled edge N is presented on uo_out/uio_out after
// enabled edge N+4; ena=0 freezes every stage, reset clears every stage.
module rect_cyl
  import rect_cyl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,     // synchronous, active-high despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,     // x
  input  logic [7:0] uio_in,    // y
  output logic [7:0] uo_out,    // r
  output logic [7:0] uio_out,   // theta, degrees
  output logic [7:0] uio_oe
);

  // Stage 0: raw inputs for the radius, normalised vector for the angle
  logic [IN_W-1:0]   x0_q, y0_q;
  cordic_t           c0_d, c0_q;
  logic [2:0]        sh0;
  logic [IN_W-1:0]   xn0, yn0;

  // Stages 1..3
  logic [SQ_W-1:0]   sq1;
  logic [ROOT_W-1:0] root3;
  cordic_t           c1_d, c1_q, c2_d, c2_q;
  logic [ZW-1:0]     z3_d, z3_q;
  theta_sel_e        sel3_q;

  // Output stage
  logic [7:0]        r_d, r_q, th_d, th_q;

  // Stage-0 capture: normalise for CORDIC and classify exact angles.
  always_comb begin
    sh0      = norm_shift(ui_in | uio_in);
    xn0      = ui_in << sh0;
    yn0      = uio_in << sh0;
    c0_d.x   = {2'b00, xn0};
    c0_d.y   = {2'b00, yn0};
    c0_d.z   = '0;
    c0_d.sel = SEL_CORDIC;
    if (uio_in == 8'd0)       c0_d.sel = SEL_0;
    else if (ui_in == 8'd0)   c0_d.sel = SEL_90;
    else if (ui_in == uio_in) c0_d.sel = SEL_45;
  end

  // Sum of squares feeding the square root pipeline.
  always_comb begin
    sq1 = {9'd0, x0_q} * {9'd0, x0_q} + {9'd0, y0_q} * {9'd0, y0_q};
  end

  rect_cyl_isqrt u_isqrt (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .ena_i  (ena),
    .sq_i   (sq1),
    .root_o (root3)
  );

  // CORDIC iterations 0-2, 3-5 and 6-7 across stages 1..3.
  always_comb begin
    c1_d = cordic_step(cordic_step(cordic_step(c0_q, 3'd0), 3'd1), 3'd2);
    c2_d = cordic_step(cordic_step(cordic_step(c1_q, 3'd3), 3'd4), 3'd5);
    z3_d = cordic_last2(c2_q);
  end

  // Output stage: saturate the root, pick exact or rounded CORDIC angle.
  always_comb begin
    r_d = root3[ROOT_W-1] ? 8'hFF : root3[7:0];
    case (sel3_q)
      SEL_0:   th_d = 8'd0;
      SEL_45:  th_d = 8'd45;
      SEL_90:  th_d = 8'd90;
      default: th_d = theta_round(z3_q);
    endcase
  end

  // Pipeline registers; reset wins over ena.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      x0_q   <= '0;
      y0_q   <= '0;
      c0_q   <= '0;
      c1_q   <= '0;
      c2_q   <= '0;
      z3_q   <= '0;
      sel3_q <= SEL_CORDIC;
      r_q    <= '0;
      th_q   <= '0;
    end else if (ena) begin
      x0_q   <= ui_in;
      y0_q   <= uio_in;
      c0_q   <= c0_d;
      c1_q   <= c1_d;
      c2_q   <= c2_d;
      z3_q   <= z3_d;
      sel3_q <= c2_q.sel;
      r_q    <= r_d;
      th_q   <= th_d;
    end
  end

  assign uo_out  = r_q;
  assign uio_out = th_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_rect_cyl.sv
// Bench for rect_cyl: directed vectors plus a floor-sqrt / atan2 reference,
// expected results queued at issue and checked by an independent monitor.
module tb_rect_cyl;

  localparam int EW = 18;   // {r[7:0], theta[7:0], tol[1:0]}

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  rect_cyl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp = '0;
  int            n_vec = 0;
  int            n_bad = 0;
  int            n_out = 0;

  // Tag marks an issued vector; it travels through the 5 sampling edges
  // (input capture + 4 latency edges) that the DUT promises.
  logic       tag_in;
  logic [4:0] tag_q;
  logic       adv_q;

  always @(posedge clk) begin
    if (rst_n) begin
      tag_q <= '0;
      adv_q <= 1'b0;
    end else begin
      adv_q <= ena;
      if (ena) tag_q <= {tag_q[3:0], tag_in};
    end
  end

  task automatic check_out(input string nm, input logic [EW-1:0] e);
    int er, et, tol, d;
    er  = int'(e[17:10]);
    et  = int'(e[9:2]);
    tol = int'(e[1:0]);
    d   = int'(uio_out) - et;
    if (d < 0) d = -d;
    n_vec++;
    if ($isunknown({uo_out, uio_out}) || int'(uo_out) != er || d > tol) begin
      n_bad++;
      $display("FAIL %s: got r=%0d theta=%0d, want r=%0d theta=%0d (+/-%0d)",
               nm, uo_out, uio_out, er, et, tol);
    end
  endtask

  // Monitor: a fresh tagged result pops the queue; a frozen cycle must
  // still show the previous result.
  always @(negedge clk) begin
    if (tag_q[4] === 1'b1) begin
      if (adv_q) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL queue_underflow: result presented with no expected entry");
        end else begin
          last_exp = exp_q.pop_front();
          n_out++;
          check_out($sformatf("out%0d", n_out), last_exp);
        end
      end else begin
        check_out($sformatf("hold_after_out%0d", n_out), last_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [7:0] x, input logic [7:0] y,
                       input int r, input int th, input int tol);
    ui_in  = x;
    uio_in = y;
    ena    = 1'b1;
    tag_in = 1'b1;
    exp_q.push_back({8'(r), 8'(th), 2'(tol)});
    @(negedge clk);
  endtask

  task automatic apply_model(input logic [7:0] x, input logic [7:0] y);
    int  xi, yi, s, r, th, tol;
    real a;
    xi = int'(x);
    yi = int'(y);
    s  = xi * xi + yi * yi;
    r  = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    if (r > 255) r = 255;
    tol = 0;
    if (yi == 0)       th = 0;
    else if (xi == 0)  th = 90;
    else if (xi == yi) th = 45;
    else begin
      a   = $atan2(real'(yi), real'(xi)) * 180.0 / 3.141592653589793;
      th  = $rtoi(a + 0.5);
      tol = 1;
    end
    apply(x, y, r, th, tol);
  endtask

  task automatic idle(input int n);
    ena    = 1'b1;
    tag_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic freeze(input int n);
    ena    = 1'b0;
    tag_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = '0;
    uio_in = '0;
    tag_in = 1'b0;
    repeat (2) @(negedge clk);
    check_out("reset_state", {8'd0, 8'd0, 2'd0});
    rst_n = 1'b0;

    // zero vector, then held (3,4)
    apply(8'd0, 8'd0, 0, 0, 0);
    repeat (3) apply(8'd3, 8'd4, 5, 53, 1);
    // axis cases are exact
    repeat (2) apply(8'd5, 8'd0, 5, 0, 0);
    repeat (2) apply(8'd0, 8'd5, 5, 90, 0);
    // 8,6 and saturation
    apply(8'd8, 8'd6, 10, 37, 1);
    apply(8'd255, 8'd255, 255, 45, 0);
    // back-to-back, then a 2-cycle stall with results in flight
    apply(8'd3, 8'd4, 5, 53, 1);
    apply(8'd5, 8'd0, 5, 0, 0);
    apply(8'd8, 8'd6, 10, 37, 1);
    freeze(2);
    idle(2);

    // boundaries of the radius and angle ranges
    apply(8'd255, 8'd0,   255, 0,  0);
    apply(8'd0,   8'd255, 255, 90, 0);
    apply(8'd1,   8'd1,   1,   45, 0);
    apply(8'd1,   8'd255, 255, 90, 1);
    apply(8'd255, 8'd1,   255, 0,  1);
    apply(8'd180, 8'd180, 254, 45, 0);
    apply(8'd181, 8'd181, 255, 45, 0);
    apply(8'd200, 8'd150, 250, 37, 1);
    apply(8'd1,   8'd2,   2,   63, 1);

    // mid-stream reset discards in-flight samples
    apply_model(8'd100, 8'd50);
    apply_model(8'd17,  8'd200);
    apply_model(8'd77,  8'd77);
    rst_n  = 1'b1;
    ena    = 1'b1;
    tag_in = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check_out("reset_mid_stream", {8'd0, 8'd0, 2'd0});
    rst_n = 1'b0;

    // first results after release, then random sweep against the model
    apply(8'd3, 8'd4, 5, 53, 1);
    repeat (25) apply_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    repeat (10) apply_model(8'($urandom_range(0, 15)),  8'($urandom_range(0, 15)));
    apply_model(8'd200, 8'd7);
    freeze(1);
    repeat (5) apply_model(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));

    // drain with a bounded wait
    ena    = 1'b1;
    tag_in = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
